conv1_sequencer: RTL and testbench

Run-level controller for the first convolution layer. On a start request it holds the layer's clock-enable and drives the input-image read address. It then tracks per-channel and all-channel completion and counts pooled results. At the end it pulses the layer's process-end reset and reports done or error. It sits between the top-level frame control and the conv-layer-1 instance, and is the only driver of that layer's `ce` and `rst_processEnd`.

---
 rtl/conv1_sequencer.sv | 152 +++++++++++++++
 tb/tb_conv1_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_sequencer.sv
// Run-level controller for conv layer 1: owns the layer clock-enable and process-end clear,
// drives the image read address and checks result/channel counts at the end of each run.
module conv1_sequencer #(
    parameter int I_SIZE  = 28,
    parameter int K_SIZE  = 5,
    parameter int P_SIZE  = 2,
    parameter int CO      = 4,
    parameter int ADDR_BW = 10,
    parameter int CNT_BW  = 10,
    parameter int TIMEOUT = 8192
) (
    input  logic                   clk,
    input  logic                   global_rst_n,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic                   i_hold,
    input  logic                   i_ch_end,
    input  logic                   i_allch_end,
    input  logic                   i_res_en,
    output logic                   o_ce,
    output logic                   o_rst_processEnd,
    output logic [ADDR_BW-1:0]     o_img_addr,
    output logic [$clog2(CO)-1:0]  o_ch_idx,
    output logic [CNT_BW-1:0]      o_res_cnt,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err
);

    localparam int CH_W   = $clog2(CO);
    localparam int TO_BW  = $clog2(TIMEOUT + 1);
    localparam int CHC_BW = $clog2(CO + 2);
    localparam int POOL   = (I_SIZE - K_SIZE + 1) / P_SIZE;

    localparam logic [ADDR_BW-1:0] ADDR_LAST = ADDR_BW'(I_SIZE * I_SIZE - 1);
    localparam logic [CNT_BW-1:0]  RES_EXP   = CNT_BW'(CO * POOL * POOL);
    localparam logic [CH_W-1:0]    CH_LAST   = CH_W'(CO - 1);
    localparam logic [CHC_BW-1:0]  CHC_EXP   = CHC_BW'(CO);
    localparam logic [TO_BW-1:0]   TO_LAST   = TO_BW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, CLEAR, FIN} state_t;

    state_t              state;
    logic                aborted;
    logic [TO_BW-1:0]    to_cnt;
    logic [CHC_BW-1:0]   ch_cnt;

    logic [ADDR_BW-1:0]  addr_nxt;
    logic [CH_W-1:0]     ch_idx_nxt;
    logic [CHC_BW-1:0]   ch_cnt_nxt;
    logic [CNT_BW-1:0]   res_nxt;
    logic [TO_BW-1:0]    to_nxt;
    logic                timeout_hit;
    logic                run_bad;

    assign o_ce = (state == RUN) && !i_hold;

    // Timeout fires on the ce cycle that brings the counter to TIMEOUT, so exactly TIMEOUT ce cycles occur.
    assign timeout_hit = o_ce && (to_cnt == TO_LAST);

    always_comb begin
        addr_nxt   = o_img_addr;
        to_nxt     = to_cnt;
        ch_idx_nxt = o_ch_idx;
        ch_cnt_nxt = ch_cnt;
        res_nxt    = o_res_cnt;
        if (o_ce) begin
            to_nxt = to_cnt + 1'b1;
            if (o_img_addr != ADDR_LAST)
                addr_nxt = o_img_addr + 1'b1;
        end
        if (state != IDLE) begin
            if (i_ch_end) begin
                ch_idx_nxt = (o_ch_idx == CH_LAST) ? '0 : o_ch_idx + 1'b1;
                if (ch_cnt != '1)
                    ch_cnt_nxt = ch_cnt + 1'b1;
            end
            if (i_res_en && o_res_cnt != '1)
                res_nxt = o_res_cnt + 1'b1;
        end
    end

    // Checked with the next-cycle counts so o_err is already valid alongside o_done in FIN.
    assign run_bad = (res_nxt != RES_EXP) || (ch_cnt_nxt != CHC_EXP);

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state            <= IDLE;
            aborted          <= 1'b0;
            to_cnt           <= '0;
            ch_cnt           <= '0;
            o_img_addr       <= '0;
            o_ch_idx         <= '0;
            o_res_cnt        <= '0;
            o_rst_processEnd <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_err            <= 1'b0;
        end else begin
            o_img_addr       <= addr_nxt;
            o_ch_idx         <= ch_idx_nxt;
            o_res_cnt        <= res_nxt;
            ch_cnt           <= ch_cnt_nxt;
            to_cnt           <= to_nxt;
            o_rst_processEnd <= 1'b0;
            o_done           <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state      <= RUN;
                        o_busy     <= 1'b1;
                        o_img_addr <= '0;
                        o_ch_idx   <= '0;
                        o_res_cnt  <= '0;
                        ch_cnt     <= '0;
                        to_cnt     <= '0;
                        o_err      <= 1'b0;
                        aborted    <= 1'b0;
                    end
                end
                RUN: begin
                    if (i_abort) begin
                        aborted          <= 1'b1;
                        state            <= CLEAR;
                        o_rst_processEnd <= 1'b1;
                    end else if (timeout_hit) begin
                        o_err            <= 1'b1;
                        state            <= CLEAR;
                        o_rst_processEnd <= 1'b1;
                    end else if (i_allch_end) begin
                        state            <= CLEAR;
                        o_rst_processEnd <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= FIN;
                    if (!aborted) begin
                        o_done <= 1'b1;
                        if (run_bad)
                            o_err <= 1'b1;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1_sequencer.sv
// Scenario bench for conv1_sequencer: default instance plus a TIMEOUT=1000 instance,
// with end-of-run expectations queued at stimulus time and checked when the run closes.
module tb_conv1_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, start_to = 1'b0;
    logic       abort = 1'b0, hold = 1'b0, ch_end = 1'b0, allch = 1'b0, res_en = 1'b0;

    logic       ce, rpe, busy, done, err;
    logic [9:0] addr, res_cnt;
    logic [1:0] ch_idx;
    logic       t_ce, t_rpe, t_busy, t_done, t_err;
    logic [9:0] t_addr, t_res_cnt;
    logic [1:0] t_ch_idx;

    logic       sel_to = 1'b0;
    logic       mon_ce, mon_rpe, mon_busy, mon_done, mon_err;
    logic [9:0] mon_addr, mon_res;

    typedef struct {
        logic       done;
        logic       err;
        logic [9:0] res;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int m_i      = 0;
    int m_addr   = 0;

    always #5 clk = ~clk;

    conv1_sequencer dut (
        .clk(clk), .global_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_hold(hold),
        .i_ch_end(ch_end), .i_allch_end(allch), .i_res_en(res_en),
        .o_ce(ce), .o_rst_processEnd(rpe), .o_img_addr(addr), .o_ch_idx(ch_idx),
        .o_res_cnt(res_cnt), .o_busy(busy), .o_done(done), .o_err(err)
    );

    conv1_sequencer #(.TIMEOUT(1000)) dut_to (
        .clk(clk), .global_rst_n(rst_n), .i_start(start_to), .i_abort(abort), .i_hold(hold),
        .i_ch_end(ch_end), .i_allch_end(allch), .i_res_en(res_en),
        .o_ce(t_ce), .o_rst_processEnd(t_rpe), .o_img_addr(t_addr), .o_ch_idx(t_ch_idx),
        .o_res_cnt(t_res_cnt), .o_busy(t_busy), .o_done(t_done), .o_err(t_err)
    );

    assign mon_ce   = sel_to ? t_ce      : ce;
    assign mon_rpe  = sel_to ? t_rpe     : rpe;
    assign mon_busy = sel_to ? t_busy    : busy;
    assign mon_done = sel_to ? t_done    : done;
    assign mon_err  = sel_to ? t_err     : err;
    assign mon_addr = sel_to ? t_addr    : addr;
    assign mon_res  = sel_to ? t_res_cnt : res_cnt;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 1'b0; start_to = 1'b0; abort = 1'b0; hold = 1'b0;
        ch_end = 1'b0; allch = 1'b0; res_en = 1'b0;
    endtask

    task automatic do_start();
        next_cycle();
        clear_inputs();
        if (sel_to) start_to = 1'b1;
        else start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mon_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_idle: busy=%b required 0", mon_busy);
        end
        m_i = 0;
        m_addr = 0;
    endtask

    // Model: addr advances on each non-hold cycle and saturates at 783; ce = !hold while running.
    task automatic run_cycles(input string name, input int n, input int hold_start,
                              input int hold_len, input int n_res);
        int bad = 0;
        int bad_i = -1;
        int bad_addr = 0, bad_exp = 0;
        logic bad_ce = 1'b0;
        for (int k = 0; k < n; k++) begin
            logic h;
            next_cycle();
            start = 1'b0; start_to = 1'b0;
            h = (m_i >= hold_start) && (m_i < hold_start + hold_len);
            hold   = h;
            res_en = (m_i < n_res);
            ch_end = (m_i < 576) && (m_i % 144 == 143);
            @(negedge clk);
            if (mon_ce !== !h || mon_addr !== 10'(m_addr) || mon_busy !== 1'b1 || mon_err !== 1'b0) begin
                if (bad == 0) begin
                    bad_i = m_i; bad_addr = int'(mon_addr); bad_exp = m_addr; bad_ce = mon_ce;
                end
                bad++;
            end
            if (!h && m_addr < 783) m_addr++;
            m_i++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL run_%s: %0d bad cycles, first i=%0d addr=%0d required %0d ce=%b",
                     name, bad, bad_i, bad_addr, bad_exp, bad_ce);
        end
    endtask

    task automatic end_of_run(input string name, input int exp_wait);
        int w = 0;
        exp_t e;
        do begin
            next_cycle();
            clear_inputs();
            @(negedge clk);
            w++;
        end while (!mon_rpe && w < 50);
        n_checks++;
        if (w !== exp_wait || mon_rpe !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_rpe_delay: rst_processEnd after %0d cycles (rpe=%b) required %0d",
                     name, w, mon_rpe, exp_wait);
        end
        n_checks++;
        if (mon_ce !== 1'b0 || mon_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_clear: ce=%b done=%b required 0 0", name, mon_ce, mon_done);
        end
        if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s_queue: no expectation queued", name);
            return;
        end
        e = exp_q.pop_front();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (mon_rpe !== 1'b0 || mon_done !== e.done) begin
            n_fail++;
            $display("FAIL %s_done: rpe=%b done=%b required 0 %b", name, mon_rpe, mon_done, e.done);
        end
        n_checks++;
        if (mon_err !== e.err) begin
            n_fail++;
            $display("FAIL %s_err: err=%b required %b", name, mon_err, e.err);
        end
        n_checks++;
        if (mon_res !== e.res) begin
            n_fail++;
            $display("FAIL %s_res_cnt: res_cnt=%0d required %0d", name, mon_res, e.res);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (mon_busy !== 1'b0 || mon_done !== 1'b0 || mon_err !== e.err) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%b done=%b err=%b required 0 0 %b",
                     name, mon_busy, mon_done, mon_err, e.err);
        end
    endtask

    task automatic drive_end(input logic ab, input logic ac, input exp_t e);
        next_cycle();
        clear_inputs();
        abort = ab;
        allch = ac;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ce, rpe, busy, done, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ce,rpe,busy,done,err=%b required 00000", {ce, rpe, busy, done, err});
        end
        n_checks++;
        if (addr !== 10'd0 || ch_idx !== 2'd0 || res_cnt !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_counts: addr=%0d ch=%0d res=%0d required 0", addr, ch_idx, res_cnt);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ce !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b ce=%b required 0 0", busy, ce);
        end
    endtask

    task automatic test_nominal();
        do_start();
        run_cycles("nominal", 850, 1 << 30, 0, 576);
        n_checks++;
        if (addr !== 10'd783) begin
            n_fail++;
            $display("FAIL nominal_addr_sat: addr=%0d required 783", addr);
        end
        drive_end(1'b0, 1'b1, '{done: 1'b1, err: 1'b0, res: 10'd576});
        n_checks++;
        if (ce !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_ce_allch: ce=%b required 1", ce);
        end
        end_of_run("nominal", 1);
        n_checks++;
        if (ch_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL nominal_ch_idx: ch_idx=%0d required 0", ch_idx);
        end
    endtask

    task automatic test_hold();
        do_start();
        run_cycles("hold_a", 112, 100, 10, 576);
        n_checks++;
        if (addr !== 10'd101) begin
            n_fail++;
            $display("FAIL hold_resume_addr: addr=%0d required 101", addr);
        end
        run_cycles("hold_b", 800, 100, 10, 576);
        drive_end(1'b0, 1'b1, '{done: 1'b1, err: 1'b0, res: 10'd576});
        end_of_run("hold", 1);
    endtask

    task automatic test_short_count();
        do_start();
        run_cycles("short", 600, 1 << 30, 0, 575);
        drive_end(1'b0, 1'b1, '{done: 1'b1, err: 1'b1, res: 10'd575});
        end_of_run("short", 1);
    endtask

    task automatic test_timeout();
        sel_to = 1'b1;
        exp_q.push_back('{done: 1'b1, err: 1'b1, res: 10'd576});
        do_start();
        run_cycles("timeout", 1005, 50, 5, 576);
        end_of_run("timeout", 1);
        sel_to = 1'b0;
    endtask

    task automatic test_abort();
        do_start();
        run_cycles("abort", 300, 1 << 30, 0, 576);
        drive_end(1'b1, 1'b1, '{done: 1'b0, err: 1'b0, res: 10'd300});
        n_checks++;
        if (addr !== 10'd300) begin
            n_fail++;
            $display("FAIL abort_addr: addr=%0d required 300", addr);
        end
        end_of_run("abort", 1);
        n_checks++;
        if (ch_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL abort_ch_idx: ch_idx=%0d required 2", ch_idx);
        end
        do_start();
        run_cycles("abort_restart", 3, 1 << 30, 0, 576);
        drive_end(1'b1, 1'b0, '{done: 1'b0, err: 1'b0, res: 10'd3});
        end_of_run("abort_restart", 1);
    endtask

    task automatic test_reset_midrun();
        bit saw_rpe = 1'b0;
        do_start();
        run_cycles("midrun", 501, 1 << 30, 0, 576);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ce, rpe, busy, done, err} !== 5'b0 || addr !== 10'd0 || res_cnt !== 10'd0 || ch_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL midrun_async: ce,rpe,busy,done,err=%b addr=%0d res=%0d ch=%0d required all 0",
                     {ce, rpe, busy, done, err}, addr, res_cnt, ch_idx);
        end
        clear_inputs();
        repeat (3) begin
            @(negedge clk);
            if (rpe) saw_rpe = 1'b1;
        end
        next_cycle();
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (rpe) saw_rpe = 1'b1;
        end
        n_checks++;
        if (saw_rpe) begin
            n_fail++;
            $display("FAIL midrun_no_rpe: rst_processEnd=1 seen required 0");
        end
        do_start();
        run_cycles("midrun_restart", 2, 1 << 30, 0, 576);
        drive_end(1'b1, 1'b0, '{done: 1'b0, err: 1'b0, res: 10'd2});
        end_of_run("midrun_restart", 1);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_hold();
        test_short_count();
        test_timeout();
        test_abort();
        test_reset_midrun();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expectations left required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
